mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes the two forwarded register-file read operands (rs, rt) and executes mult/multu/div/divu over a fixed multi-cycle latency, plus single-cycle mthi/mtlo. It holds the architectural HI/LO registers, whose values return to the register file through the mfhi/mflo write-back path. It reports busy status so the hazard unit can stall any dependent instruction.

## Interface
- MULT_CYCLES, 5: cycles busy stays high for mult/multu; legal range 1..31.
- DIV_CYCLES, 10: cycles busy stays high for div/divu; legal range 1..31.

- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- start  in  1  op valid this cycle; may be held high only for one cycle per instruction.
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
- A  in  32  rs operand (forwarded value).
- B  in  32  rt operand (forwarded value).
- busy  out  1  registered; high while a mult/div is in flight.
- stall_req  out  1  combinational: busy | (start & op<=3); drives hazard-unit stall for any HI/LO-touching instruction.
- HI  out  32  registered HI register.
- LO  out  32  registered LO register.

## Operation
- States: IDLE, MUL, DIV. Internal down-counter is 5 bits wide; result regs are res_hi/res_lo.
- IDLE + start + op in {0,1}:
  - Latch the 64-bit product, signed (op 0) or unsigned (op 1), into res_hi/res_lo.
  - Load counter with MULT_CYCLES and go to MUL.
- IDLE + start + op in {2,3}:
  - Latch quotient into res_lo and remainder into res_hi.
  - Load counter with DIV_CYCLES and go to DIV.
- IDLE + start + op 4: HI <= A at this edge; op 5: LO <= A. Stay IDLE, busy stays 0.
- IDLE + start + op 6/7: no effect.
- MUL/DIV: decrement counter each edge. At the edge where the counter reaches 0:
  - HI <= res_hi and LO <= res_lo.
  - busy falls; return to IDLE.
- start while busy: ignored completely (hazard unit guarantees it does not happen; the bench checks that it is ignored).
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B==0, op 2/3): full DIV_CYCLES busy period runs. At completion HI/LO keep their prior values (no write).
- HI/LO are never visible mid-operation: they change only at completion or on mthi/mtlo.
- Reset: HI=0, LO=0, busy=0, state IDLE, counter 0; any in-flight result is discarded. Reset dominates start in the same cycle.

## Timing
- start accepted at edge N (op 0-3) means busy=1 from after edge N until edge N+L, with L = MULT_CYCLES or DIV_CYCLES.
  - HI/LO update at edge N+L; busy=0 after edge N+L.
  - busy is high for exactly L cycles.
- stall_req rises in the same cycle start is asserted (before edge N). It stays high through the cycle before edge N+L.
- A new start is accepted at edge N+L+1 at the earliest. Back-to-back ops have no extra gap beyond busy.
- mthi/mtlo: HI/LO visible in the cycle after the accepting edge. Latency 1, no busy.
- Reset asserted at any edge during MUL/DIV: outputs are reset values after that edge; no late HI/LO write occurs.
- Outputs HI, LO, busy are glitch-free registered values. stall_req is the only combinational output.

## Test plan
- Signed vs unsigned multiply, both with A=0xFFFFFFFF, B=2:
  - op 0 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE after exactly 5 cycles; busy high 5 cycles.
  - op 1 -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide, A=0xFFFFFFF9 (-7), B=2, op 2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then op 3 with A=7, B=2 -> LO=3, HI=1.
- Divide by zero: preload via mthi 0x1234 / mtlo 0x5678, then op 2 with B=0.
  - busy high 10 cycles; HI=0x1234, LO=0x5678 unchanged afterward.
- Overflow divide: A=0x80000000, B=0xFFFFFFFF, op 2 -> LO=0x80000000, HI=0.
- Start ignored and reset mid-op:
  - Issue mult 3*4, then start mtlo 0x99 on cycle 2 while busy -> LO=12, HI=0 at completion; 0x99 never appears.
  - Issue div 100/7, assert reset at cycle 4 -> HI=LO=0 and busy=0 next cycle; no write at cycle 10.
- stall_req check: with start=1, op=0 and busy=0, stall_req=1 combinationally. With op=4, stall_req=0.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and result bundle between the EX-stage issue logic and the multiply/divide unit.
// The master drives the operation request; the slave returns busy, stall and HI/LO.
interface mdu_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        stall_req;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, op, A, B, input busy, stall_req, HI, LO);
   modport slave  (input start, op, A, B, output busy, stall_req, HI, LO);
endinterface

// File: rtl/mdu.sv
// MIPS multiply/divide unit: computes mult/multu/div/divu at issue, then holds the
// result back for a fixed busy period before committing it to the architectural HI/LO.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [4:0] MUL_LD = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_LD = 5'(DIV_CYCLES);

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        divz_q, divz_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

   logic [63:0] prod;
   logic        div_sgn, neg_a, neg_b;
   logic [31:0] abs_a, abs_b, qmag, rmag, quot, rem;

   // Divide on magnitudes so the most-negative / -1 case wraps instead of overflowing.
   always_comb begin
      if (bus.op == 3'd0)
         prod = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
      else
         prod = {32'd0, bus.A} * {32'd0, bus.B};
      div_sgn = (bus.op == 3'd2);
      neg_a   = div_sgn & bus.A[31];
      neg_b   = div_sgn & bus.B[31];
      abs_a   = neg_a ? (~bus.A + 32'd1) : bus.A;
      abs_b   = neg_b ? (~bus.B + 32'd1) : bus.B;
      qmag    = 32'd0;
      rmag    = 32'd0;
      if (abs_b != 32'd0) begin
         qmag = abs_a / abs_b;
         rmag = abs_a % abs_b;
      end
      quot = (neg_a ^ neg_b) ? (~qmag + 32'd1) : qmag;
      rem  = neg_a ? (~rmag + 32'd1) : rmag;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      divz_d   = divz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      if (state_q == S_IDLE) begin
         if (bus.start) begin
            case (bus.op)
               3'd0, 3'd1: begin
                  res_hi_d = prod[63:32];
                  res_lo_d = prod[31:0];
                  cnt_d    = MUL_LD;
                  state_d  = S_MUL;
                  busy_d   = 1'b1;
               end
               3'd2, 3'd3: begin
                  res_hi_d = rem;
                  res_lo_d = quot;
                  divz_d   = (bus.B == 32'd0);
                  cnt_d    = DIV_LD;
                  state_d  = S_DIV;
                  busy_d   = 1'b1;
               end
               3'd4:    hi_d = bus.A;
               3'd5:    lo_d = bus.A;
               default: ;
            endcase
         end
      end else if (cnt_q == 5'd1) begin
         // Divide by zero completes silently, leaving HI/LO untouched.
         if (!(state_q == S_DIV && divz_q)) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
         end
         cnt_d   = 5'd0;
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         cnt_d = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         busy_q  <= 1'b0;
         divz_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         divz_q  <= divz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
   end

   assign bus.busy      = busy_q;
   assign bus.stall_req = busy_q | (bus.start & (bus.op <= 3'd3));
   assign bus.HI        = hi_q;
   assign bus.LO        = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for the multiply/divide unit with hand-computed HI/LO results.
module tb_mdu;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   cyc;

   mdu_if bus ();

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = 3'd7;
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 3'd7; bus.A = 32'd0; bus.B = 32'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_hi", bus.HI, 32'd0);
      chk("reset_lo", bus.LO, 32'd0);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);

      // combinational stall request
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd1; bus.B = 32'd1;
      #1 chk("stall_mult", {31'd0, bus.stall_req}, 32'd1);
      bus.op = 3'd4;
      #1 chk("stall_mthi", {31'd0, bus.stall_req}, 32'd0);
      bus.start = 1'b0; bus.op = 3'd7;

      run_op(3'd0, 32'hFFFF_FFFF, 32'd2, cyc);
      chk("mult_cycles", 32'(cyc), 32'd5);
      chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
      chk("mult_lo", bus.LO, 32'hFFFF_FFFE);

      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, cyc);
      chk("multu_cycles", 32'(cyc), 32'd5);
      chk("multu_hi", bus.HI, 32'h0000_0001);
      chk("multu_lo", bus.LO, 32'hFFFF_FFFE);

      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
      chk("div_cycles", 32'(cyc), 32'd10);
      chk("div_hi", bus.HI, 32'hFFFF_FFFF);
      chk("div_lo", bus.LO, 32'hFFFF_FFFD);

      run_op(3'd3, 32'd7, 32'd2, cyc);
      chk("divu_hi", bus.HI, 32'd1);
      chk("divu_lo", bus.LO, 32'd3);

      run_op(3'd4, 32'h1234, 32'd0, cyc);
      chk("mthi_hi", bus.HI, 32'h1234);
      chk("mthi_busy", 32'(cyc), 32'd0);
      run_op(3'd5, 32'h5678, 32'd0, cyc);
      chk("mtlo_lo", bus.LO, 32'h5678);
      chk("mtlo_hi_kept", bus.HI, 32'h1234);

      run_op(3'd2, 32'd55, 32'd0, cyc);
      chk("divz_cycles", 32'(cyc), 32'd10);
      chk("divz_hi", bus.HI, 32'h1234);
      chk("divz_lo", bus.LO, 32'h5678);

      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      chk("ovf_hi", bus.HI, 32'd0);
      chk("ovf_lo", bus.LO, 32'h8000_0000);

      // mtlo issued while a multiply is in flight must be dropped
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = 3'd7;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'h99;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = 3'd7;
      chk("ign_lo_mid", bus.LO, 32'h8000_0000);
      chk("ign_stall_mid", {31'd0, bus.stall_req}, 32'd1);
      cyc = 1;
      while (bus.busy === 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("ign_cycles", 32'(cyc), 32'd5);
      chk("ign_hi", bus.HI, 32'd0);
      chk("ign_lo", bus.LO, 32'd12);

      // reset during a divide discards the pending result
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = 3'd7;
      repeat (3) @(posedge clk);
      #1 chk("rst_busy_before", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("rst_late_hi", bus.HI, 32'd0);
      chk("rst_late_lo", bus.LO, 32'd0);
      chk("rst_late_busy", {31'd0, bus.busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
